// File: rtl/hub75_bcm_driver.sv
// rtl/hub75_bcm_driver.sv - HUB75 scan driver with binary-coded-modulation colour depth.
// Shifts each bit-plane of a row, latches it while blanked, then lights it for BASE_ON<<plane cycles.
module hub75_bcm_driver #(
  parameter int COLS      = 64,
  parameter int SCAN_ROWS = 16,
  parameter int BPC       = 4,
  parameter int BASE_ON   = 8,
  localparam int RB = $clog2(SCAN_ROWS),
  localparam int CB = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             fb_rd,
  output logic [RB+CB-1:0] fb_addr,
  input  logic [6*BPC-1:0] fb_data,
  output logic [RB-1:0]    row_addr,
  output logic             R0,
  output logic             G0,
  output logic             B0,
  output logic             R1,
  output logic             G1,
  output logic             B1,
  output logic             SCLK,
  output logic             LAT,
  output logic             OE,
  output logic             frame_done
);

  localparam int SW = CB + 1;
  localparam int PW = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int DW = $clog2((BASE_ON << (BPC - 1)) + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t           state_q, state_d;
  logic [RB-1:0]    row_q, row_d;
  logic [PW-1:0]    plane_q, plane_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic             phase_q, phase_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [5:0]       rgb_q, rgb_d;
  logic [RB-1:0]    row_addr_q, row_addr_d;
  logic             fb_rd_q, fb_rd_d;
  logic [RB+CB-1:0] fb_addr_q, fb_addr_d;
  logic             sclk_q, sclk_d;
  logic             lat_q, lat_d;
  logic             oe_q, oe_d;
  logic             frame_done_q, frame_done_d;
  logic [BPC-1:0]   field;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    plane_d      = plane_q;
    slot_d       = slot_q;
    phase_d      = phase_q;
    dcnt_d       = dcnt_q;
    rgb_d        = rgb_q;
    row_addr_d   = row_addr_q;
    frame_done_d = 1'b0;
    field        = '0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SHIFT;
          row_d   = '0;
          plane_d = '0;
          slot_d  = '0;
          phase_d = 1'b0;
        end
      end
      SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          // Read data returned during phase 1 is captured here and clocked out in the next slot.
          if (slot_q < SW'(COLS)) begin
            for (int j = 0; j < 6; j++) begin
              field    = fb_data[j*BPC +: BPC];
              rgb_d[j] = field[plane_q];
            end
          end
          phase_d = 1'b0;
          if (slot_q == SW'(COLS)) begin
            state_d = LATCH;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + SW'(1);
          end
        end
      end
      LATCH: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          state_d = DISPLAY;
          dcnt_d  = DW'(BASE_ON) << plane_q;
        end
      end
      DISPLAY: begin
        if (dcnt_q == DW'(1)) begin
          if (plane_q != PW'(BPC - 1)) begin
            plane_d = plane_q + PW'(1);
            state_d = SHIFT;
          end else if (row_q != RB'(SCAN_ROWS - 1)) begin
            row_d   = row_q + RB'(1);
            plane_d = '0;
            state_d = SHIFT;
          end else begin
            row_d        = '0;
            plane_d      = '0;
            frame_done_d = 1'b1;
            state_d      = enable ? SHIFT : IDLE;
          end
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin values are derived from the next state so every output leaves a flop.
    fb_rd_d   = (state_d == SHIFT) && !phase_d && (slot_d < SW'(COLS));
    fb_addr_d = fb_rd_d ? {row_d, slot_d[CB-1:0]} : fb_addr_q;
    sclk_d    = (state_d == SHIFT) && phase_d && (slot_d != '0);
    lat_d     = (state_d == LATCH) && !phase_d;
    oe_d      = (state_d != DISPLAY);
    if (lat_d) row_addr_d = row_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      plane_q      <= '0;
      slot_q       <= '0;
      phase_q      <= 1'b0;
      dcnt_q       <= '0;
      rgb_q        <= '0;
      row_addr_q   <= '0;
      fb_rd_q      <= 1'b0;
      fb_addr_q    <= '0;
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      slot_q       <= slot_d;
      phase_q      <= phase_d;
      dcnt_q       <= dcnt_d;
      rgb_q        <= rgb_d;
      row_addr_q   <= row_addr_d;
      fb_rd_q      <= fb_rd_d;
      fb_addr_q    <= fb_addr_d;
      sclk_q       <= sclk_d;
      lat_q        <= lat_d;
      oe_q         <= oe_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fb_rd      = fb_rd_q;
  assign fb_addr    = fb_addr_q;
  assign row_addr   = row_addr_q;
  assign {R0, G0, B0, R1, G1, B1} = rgb_q;
  assign SCLK       = sclk_q;
  assign LAT        = lat_q;
  assign OE         = oe_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb/tb_hub75_bcm_driver.sv - self-checking bench for hub75_bcm_driver (COLS=4, SCAN_ROWS=2, BPC=2, BASE_ON=2).
module tb_hub75_bcm_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fb_rd;
  logic [2:0]  fb_addr;
  logic [11:0] fb_data = '0;
  logic [0:0]  row_addr;
  logic        R0, G0, B0, R1, G1, B1;
  logic        SCLK, LAT, OE, frame_done;

  hub75_bcm_driver #(.COLS(4), .SCAN_ROWS(2), .BPC(2), .BASE_ON(2)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data),
    .row_addr(row_addr),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .SCLK(SCLK), .LAT(LAT), .OE(OE), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Fields (MSB first): R top = col, G top = ~col, B top = {row,1}, R bot = {col0,col1}, G bot = {col0,col1^col0}, B bot = {1,row}.
  function automatic logic [11:0] pix(input logic [2:0] a);
    logic       r;
    logic [1:0] c;
    r = a[2];
    c = a[1:0];
    return {c, ~c, r, 1'b1, c[0], c[1], c[0], c[1] ^ c[0], 1'b1, r};
  endfunction

  always @(posedge clk) if (fb_rd) fb_data <= pix(fb_addr);

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic mon_en = 1'b0;
  int   rel, rises, latw, oew, bad_latw, n_lat, bad_sclk, viol, b2b, rd_cnt, last_rd, oe_lo;
  int   fd_q[$];
  int   ra_q[$];
  int   oew_q[$];
  logic oe_p = 1'b1, lat_p = 1'b0, sclk_p = 1'b0, rd_p = 1'b0;
  logic [0:0] ra_p = '0;

  always @(negedge clk) begin
    if (!mon_en) begin
      rel = 0; rises = 0; latw = 0; oew = 0; bad_latw = 0; n_lat = 0; bad_sclk = 0;
      viol = 0; b2b = 0; rd_cnt = 0; last_rd = -1; oe_lo = 0;
      fd_q.delete(); ra_q.delete(); oew_q.delete();
    end else begin
      if (frame_done) fd_q.push_back(rel);
      if (row_addr != ra_p) ra_q.push_back(rel);
      if (!OE && (LAT || row_addr != ra_p)) viol++;
      if (SCLK && !sclk_p) rises++;
      if (LAT && !lat_p) begin
        n_lat++;
        if (rises != 4) bad_sclk++;
        rises = 0;
      end
      if (LAT) latw++;
      if (!LAT && lat_p) begin
        if (latw != 1) bad_latw++;
        latw = 0;
      end
      if (!OE) begin oew++; oe_lo++; end
      if (OE && !oe_p) begin oew_q.push_back(oew); oew = 0; end
      if (fb_rd) begin rd_cnt++; last_rd = rel; end
      if (fb_rd && rd_p) b2b++;
      rel++;
    end
    oe_p = OE; lat_p = LAT; sclk_p = SCLK; ra_p = row_addr; rd_p = fb_rd;
  end

  typedef struct {
    logic       en;
    logic       rd;
    logic [2:0] addr;
    logic       sclk;
    logic       lat;
    logic       oe;
    logic [5:0] rgb;
  } vec_t;

  vec_t tbl[18];

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; enable = 1'b0; mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit found;
    // Row 0 from the cycle enable is first sampled: plane-0 shift, latch, display, start of plane 1.
    tbl[ 0] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 6'b000000};
    tbl[ 1] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 6'b000000};
    tbl[ 2] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 6'b000000};
    tbl[ 3] = '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 6'b011000};
    tbl[ 4] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 6'b011000};
    tbl[ 5] = '{1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 6'b101010};
    tbl[ 6] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 6'b101010};
    tbl[ 7] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 6'b011110};
    tbl[ 8] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 6'b011110};
    tbl[ 9] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 6'b101100};
    tbl[10] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 6'b101100};
    tbl[11] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 6'b101100};
    tbl[12] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 6'b101100};
    tbl[13] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'b101100};
    tbl[14] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'b101100};
    tbl[15] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 6'b101100};
    tbl[16] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 6'b101100};
    tbl[17] = '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 6'b010001};

    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {OE, LAT, SCLK, fb_rd, fb_addr, row_addr, frame_done, R0, G0, B0, R1, G1, B1},
          {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 6'd0});
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_no_rd", rd_cnt, 0);
    check("idle_oe_high", oe_lo, 0);

    // Continuous scanning: cycle-exact vectors, then three frames of monitor statistics.
    do_reset();
    @(posedge clk); #1;
    enable = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {fb_rd, (tbl[i].rd ? fb_addr : 3'd0), SCLK, LAT, OE, row_addr, frame_done, R0, G0, B0, R1, G1, B1},
            {tbl[i].rd, tbl[i].addr, tbl[i].sclk, tbl[i].lat, tbl[i].oe, 1'b0, 1'b0, tbl[i].rgb});
      enable = tbl[i].en;
    end
    repeat (170) @(negedge clk);
    check("fd_count", fd_q.size(), 3);
    check("fd_first", (fd_q.size() > 0) ? fd_q[0] : -1, 61);
    check("fd_second", (fd_q.size() > 1) ? fd_q[1] : -1, 121);
    check("fd_third", (fd_q.size() > 2) ? fd_q[2] : -1, 181);
    check("row_to_1", (ra_q.size() > 0) ? ra_q[0] : -1, 41);
    check("row_to_0", (ra_q.size() > 1) ? ra_q[1] : -1, 71);
    check("row_to_1b", (ra_q.size() > 2) ? ra_q[2] : -1, 101);
    check("oe_low_p0", (oew_q.size() > 0) ? oew_q[0] : -1, 2);
    check("oe_low_p1", (oew_q.size() > 1) ? oew_q[1] : -1, 4);
    check("oe_low_r1p0", (oew_q.size() > 2) ? oew_q[2] : -1, 2);
    check("oe_low_r1p1", (oew_q.size() > 3) ? oew_q[3] : -1, 4);
    check("lat_count", n_lat, 12);
    check("lat_width", bad_latw, 0);
    check("sclk_per_lat", bad_sclk, 0);
    check("blank_safety", viol, 0);
    check("no_b2b_reads", b2b, 0);

    // Enable dropped mid-frame: the frame completes, then the block idles.
    do_reset();
    @(posedge clk); #1;
    enable = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(posedge clk);
    #1 enable = 1'b0;
    repeat (100) @(negedge clk);
    check("drop_fd_count", fd_q.size(), 1);
    check("drop_fd_cycle", (fd_q.size() > 0) ? fd_q[0] : -1, 61);
    check("drop_reads", rd_cnt, 16);
    check("drop_last_rd_before_end", (last_rd >= 0 && last_rd < 61), 1'b1);
    check("drop_idle_oe", OE, 1'b1);

    // Asynchronous reset in the middle of a row-1 display period.
    do_reset();
    @(posedge clk); #1;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (row_addr == 1'b1 && !OE) found = 1'b1;
    end
    check("reach_row1_display", found, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_reset", {OE, LAT, SCLK, fb_rd, row_addr}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    enable = 1'b0;
    mon_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_no_rd", rd_cnt, 0);
    check("post_reset_oe", oe_lo, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
